// File: rtl/alarm_set_pkg.sv
// Shared types and constants for the alarm setpoint editor.
package alarm_set_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StEditH = 2'd1,
    StEditM = 2'd2,
    StEditS = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FieldNone = 2'd0,
    FieldHour = 2'd1,
    FieldMin  = 2'd2,
    FieldSec  = 2'd3
  } field_e;

  localparam logic [7:0] HOUR_MAX   = 8'h23;
  localparam logic [7:0] MINSEC_MAX = 8'h59;

  function automatic field_e state_field(input state_e st);
    field_e f;
    unique case (st)
      StEditH: f = FieldHour;
      StEditM: f = FieldMin;
      StEditS: f = FieldSec;
      default: f = FieldNone;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bcd_field_adj.sv
// Combinational two-digit BCD increment/decrement with wrap at max_i.
module bcd_field_adj (
  input  logic [7:0] val_i,
  input  logic [7:0] max_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [7:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (inc_i && !dec_i) begin
      if (val_i >= max_i) begin
        val_o = 8'h00;
      end else if (val_i[3:0] >= 4'd9) begin
        val_o = {val_i[7:4] + 4'd1, 4'd0};
      end else begin
        val_o = {val_i[7:4], val_i[3:0] + 4'd1};
      end
    end else if (dec_i && !inc_i) begin
      // Out-of-range input snaps to max so the field never leaves legal BCD.
      if (val_i == 8'h00 || val_i > max_i) begin
        val_o = max_i;
      end else if (val_i[3:0] == 4'd0) begin
        val_o = {val_i[7:4] - 4'd1, 4'd9};
      end else begin
        val_o = {val_i[7:4], val_i[3:0] - 4'd1};
      end
    end
  end

endmodule

// File: rtl/alarm_set_editor.sv
// Alarm setpoint editor: edits a shadow copy per field, publishes it atomically on ok.
// Optional auto-repeat on held up/down is built when AUTOREPEAT_EN is defined.
module alarm_set_editor
  import alarm_set_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 50_000_000,
  parameter int unsigned RPT_DELAY_CYC = 25_000_000,
  parameter int unsigned RPT_RATE_CYC  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_ok,
  input  logic       btn_arm,
  output logic [7:0] alarm_h,
  output logic [7:0] alarm_m,
  output logic [7:0] alarm_s,
  output logic       alarm_armed,
  output logic       commit,
  output logic       edit_active,
  output logic [1:0] edit_field,
  output logic [7:0] shadow_val
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [7:0]      shadow_h_q, shadow_h_d, shadow_m_q, shadow_m_d, shadow_s_q, shadow_s_d;
  logic [7:0]      alarm_h_q, alarm_h_d, alarm_m_q, alarm_m_d, alarm_s_q, alarm_s_d;
  logic            armed_q, armed_d;
  logic            commit_q, commit_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [4:0]      btn_prev_q;

  logic sel_edge, up_edge, down_edge, ok_edge, arm_edge, any_edge;
  logic rpt_step, step_inc, step_dec;
  logic [7:0] cur_val, cur_max, adj_val;

  assign sel_edge  = btn_sel  & ~btn_prev_q[4];
  assign up_edge   = btn_up   & ~btn_prev_q[3];
  assign down_edge = btn_down & ~btn_prev_q[2];
  assign ok_edge   = btn_ok   & ~btn_prev_q[1];
  assign arm_edge  = btn_arm  & ~btn_prev_q[0];
  assign any_edge  = sel_edge | up_edge | down_edge | ok_edge | arm_edge;

`ifdef AUTOREPEAT_EN
  localparam int unsigned RptMax = (RPT_DELAY_CYC > RPT_RATE_CYC) ? RPT_DELAY_CYC : RPT_RATE_CYC;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_phase_q, rpt_phase_d;
  logic            held;

  assign held = (btn_up ^ btn_down) && (state_q != StIdle);

  // Count held cycles since the press; first repeat after the delay, then at the rate.
  always_comb begin
    rpt_cnt_d   = '0;
    rpt_phase_d = 1'b0;
    rpt_step    = 1'b0;
    if (held && (up_edge || down_edge)) begin
      rpt_cnt_d = RptW'(1);
    end else if (held) begin
      rpt_phase_d = rpt_phase_q;
      if (rpt_cnt_q == (rpt_phase_q ? RptW'(RPT_RATE_CYC) : RptW'(RPT_DELAY_CYC))) begin
        rpt_step    = 1'b1;
        rpt_cnt_d   = RptW'(1);
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end
`else
  logic unused_rpt;
  assign unused_rpt = ^{RPT_DELAY_CYC, RPT_RATE_CYC};
  assign rpt_step   = 1'b0;
`endif

  assign step_inc = (up_edge & ~down_edge) | (rpt_step & btn_up);
  assign step_dec = (down_edge & ~up_edge) | (rpt_step & btn_down);

  always_comb begin
    unique case (state_q)
      StEditH: begin cur_val = shadow_h_q; cur_max = HOUR_MAX;   end
      StEditM: begin cur_val = shadow_m_q; cur_max = MINSEC_MAX; end
      StEditS: begin cur_val = shadow_s_q; cur_max = MINSEC_MAX; end
      default: begin cur_val = 8'h00;      cur_max = MINSEC_MAX; end
    endcase
  end

  bcd_field_adj u_adj (
    .val_i (cur_val),
    .max_i (cur_max),
    .inc_i (step_inc),
    .dec_i (step_dec),
    .val_o (adj_val)
  );

  always_comb begin
    state_d    = state_q;
    shadow_h_d = shadow_h_q;
    shadow_m_d = shadow_m_q;
    shadow_s_d = shadow_s_q;
    alarm_h_d  = alarm_h_q;
    alarm_m_d  = alarm_m_q;
    alarm_s_d  = alarm_s_q;
    armed_d    = armed_q;
    commit_d   = 1'b0;
    tmo_d      = '0;
    if (state_q == StIdle) begin
      if (sel_edge) begin
        state_d    = StEditH;
        shadow_h_d = alarm_h_q;
        shadow_m_d = alarm_m_q;
        shadow_s_d = alarm_s_q;
      end
      // Hour 00 means "no setpoint", so arming is refused.
      if (arm_edge) begin
        armed_d = (alarm_h_q != 8'h00) ? ~armed_q : 1'b0;
      end
    end else if (ok_edge) begin
      state_d   = StIdle;
      alarm_h_d = shadow_h_q;
      alarm_m_d = shadow_m_q;
      alarm_s_d = shadow_s_q;
      commit_d  = 1'b1;
      if (shadow_h_q == 8'h00) begin
        armed_d = 1'b0;
      end
    end else if (sel_edge) begin
      unique case (state_q)
        StEditH: state_d = StEditM;
        StEditM: state_d = StEditS;
        default: state_d = StEditH;
      endcase
    end else begin
      unique case (state_q)
        StEditH: shadow_h_d = adj_val;
        StEditM: shadow_m_d = adj_val;
        default: shadow_s_d = adj_val;
      endcase
      if (any_edge || rpt_step) begin
        tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shadow_h_q <= 8'h00;
      shadow_m_q <= 8'h00;
      shadow_s_q <= 8'h00;
      alarm_h_q  <= 8'h00;
      alarm_m_q  <= 8'h00;
      alarm_s_q  <= 8'h00;
      armed_q    <= 1'b0;
      commit_q   <= 1'b0;
      tmo_q      <= '0;
      btn_prev_q <= 5'b0;
    end else begin
      state_q    <= state_d;
      shadow_h_q <= shadow_h_d;
      shadow_m_q <= shadow_m_d;
      shadow_s_q <= shadow_s_d;
      alarm_h_q  <= alarm_h_d;
      alarm_m_q  <= alarm_m_d;
      alarm_s_q  <= alarm_s_d;
      armed_q    <= armed_d;
      commit_q   <= commit_d;
      tmo_q      <= tmo_d;
      btn_prev_q <= {btn_sel, btn_up, btn_down, btn_ok, btn_arm};
    end
  end

  assign alarm_h     = alarm_h_q;
  assign alarm_m     = alarm_m_q;
  assign alarm_s     = alarm_s_q;
  assign alarm_armed = armed_q;
  assign commit      = commit_q;
  assign edit_active = (state_q != StIdle);
  assign edit_field  = state_field(state_q);
  assign shadow_val  = cur_val;

endmodule
